// File: rtl/riscv_mmio_pkg.sv
// Shared MMIO address map for the core's data bus peripherals.
// Used by the GPIO read mux and by the memory's range exclusion.
package riscv_mmio_pkg;

    localparam logic [31:0] GPIO_BASE_ADDR = 32'h1001_0080;

    localparam logic [31:0] OFF_OUT  = 32'h00;
    localparam logic [31:0] OFF_IN   = 32'h04;
    localparam logic [31:0] OFF_EDGE = 32'h08;
    localparam logic [31:0] OFF_SET  = 32'h0C;
    localparam logic [31:0] OFF_CLR  = 32'h10;

    typedef enum logic [2:0] {
        REG_OUT,
        REG_IN,
        REG_EDGE,
        REG_SET,
        REG_CLR,
        REG_NONE
    } gpio_reg_e;

    // Base is assumed word-aligned, so an aligned address gives an aligned offset.
    function automatic gpio_reg_e gpio_decode(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        logic [31:0] off;
        off = addr - base;
        if (addr[1:0] != 2'b00) return REG_NONE;
        case (off)
            OFF_OUT:  return REG_OUT;
            OFF_IN:   return REG_IN;
            OFF_EDGE: return REG_EDGE;
            OFF_SET:  return REG_SET;
            OFF_CLR:  return REG_CLR;
            default:  return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for asynchronous inputs, synchronous reset.
// Exposes both stages so callers can build edge detectors on them.
module gpio_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync1,
    output logic [WIDTH-1:0] o_sync2
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
        end
    end

    assign o_sync1 = r_sync1;
    assign o_sync2 = r_sync2;

endmodule

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: OUT with set/clear aliases, synchronized IN,
// and sticky rising-edge flags cleared by write-1.
module gpio_mmio
    import riscv_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = GPIO_BASE_ADDR,
    parameter int          GPIO_WIDTH = 8,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           Address_i,
    input  logic [DATA_WIDTH-1:0] WriteData_i,
    input  logic                  MemWrite_i,
    output logic [DATA_WIDTH-1:0] ReadData_o,
    output logic                  Sel_o,
    input  logic [GPIO_WIDTH-1:0] gpio_in_i,
    output logic [GPIO_WIDTH-1:0] gpio_out_o
);

    gpio_reg_e             w_sel;
    logic [GPIO_WIDTH-1:0] w_wdata;
    logic [GPIO_WIDTH-1:0] w_clr;
    logic [GPIO_WIDTH-1:0] w_sync1;
    logic [GPIO_WIDTH-1:0] w_sync2;
    logic                  w_unused_wdata;

    logic [GPIO_WIDTH-1:0] r_out;
    logic [GPIO_WIDTH-1:0] r_sync3;
    logic [GPIO_WIDTH-1:0] r_edge;

    assign w_sel          = gpio_decode(Address_i, BASE_ADDR);
    assign Sel_o          = (w_sel != REG_NONE);
    assign w_wdata        = WriteData_i[GPIO_WIDTH-1:0];
    assign w_unused_wdata = ^{WriteData_i[DATA_WIDTH-1:GPIO_WIDTH], w_sync1};
    assign w_clr          = (MemWrite_i && w_sel == REG_EDGE) ? w_wdata : '0;

    gpio_sync #(
        .WIDTH(GPIO_WIDTH)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_async(gpio_in_i),
        .o_sync1(w_sync1),
        .o_sync2(w_sync2)
    );

    // Set wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out   <= '0;
            r_sync3 <= '0;
            r_edge  <= '0;
        end else begin
            r_sync3 <= w_sync2;
            r_edge  <= (r_edge & ~w_clr) | (w_sync2 & ~r_sync3);
            if (MemWrite_i) begin
                case (w_sel)
                    REG_OUT: r_out <= w_wdata;
                    REG_SET: r_out <= r_out | w_wdata;
                    REG_CLR: r_out <= r_out & ~w_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        ReadData_o = '0;
        case (w_sel)
            REG_OUT:  ReadData_o[GPIO_WIDTH-1:0] = r_out;
            REG_IN:   ReadData_o[GPIO_WIDTH-1:0] = w_sync2;
            REG_EDGE: ReadData_o[GPIO_WIDTH-1:0] = r_edge;
            default:  ;
        endcase
    end

    assign gpio_out_o = r_out;

endmodule

// File: doc/gpio_mmio.md
Name: gpio_mmio

Overview:
- Memory-mapped 8-bit GPIO peripheral on the core data bus, in parallel with the instruction/data memory.
- Consumes the core's Address/WriteData/MemWrite.
- Asserts a hit flag so the top level steers its read data back to the core instead of the memory's.
- Drives gpio_port_out; samples gpio_port_in through a synchronizer with sticky rising-edge capture.

Parameters:
- BASE_ADDR, 32'h1001_0080, word-aligned base of the 5-register window.
- GPIO_WIDTH, 8, number of input pins and number of output pins.
- DATA_WIDTH, 32, bus data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Address_i  input  32  byte address from core.
- WriteData_i  input  32  store data from core.
- MemWrite_i  input  1  store strobe, one cycle per store.
- ReadData_o  output  32  register read data, combinational from Address_i.
- Sel_o  output  1  high when Address_i hits the window; top muxes ReadData_o vs memory.
- gpio_in_i  input  GPIO_WIDTH  asynchronous external pins.
- gpio_out_o  output  GPIO_WIDTH  OUT register contents.

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high.
- Reset state: OUT=0, sync1/sync2/sync3=0, EDGE=0. Outputs gpio_out_o=0; ReadData_o is 0 for any miss.
- Decode:
  - Hit requires Address_i[1:0]==0 and offset = Address_i-BASE_ADDR in {0x00,0x04,0x08,0x0C,0x10}.
  - Misaligned or other addresses: Sel_o=0, ReadData_o=0, writes ignored.
- Register map (data in bits [GPIO_WIDTH-1:0], upper bits read 0, writes to them ignored):
  - 0x00 OUT: RW.
  - 0x04 IN: RO; returns sync2. Writes ignored.
  - 0x08 EDGE: sticky rising-edge flags; read returns flags. Write-1-to-clear; write-0 leaves the bit.
  - 0x0C OUT_SET: WO; OUT <= OUT | wdata. Reads 0.
  - 0x10 OUT_CLR: WO; OUT <= OUT & ~wdata. Reads 0.
- Write timing: a store with MemWrite_i=1 at rising edge N updates the register at edge N. gpio_out_o reflects it immediately after edge N (zero extra latency).
- Input path, per bit:
  - sync1 <= gpio_in_i; sync2 <= sync1; sync3 <= sync2.
  - An input change before edge N is visible in IN after edge N+1.
- Edge detect: EDGE <= (EDGE & ~clr_mask) | (sync2 & ~sync3). The flag sets at edge N+2.
- Simultaneous events: W1C to a bit in the same cycle that bit's rising edge is detected leaves the bit set (set wins).
- Falling edges are never flagged. Input pulses shorter than one clock may be lost; this is the documented limitation.
- Post-reset: because sync regs reset to 0, a pin held high through reset sets its EDGE bit 3 cycles after reset deasserts.
- Reset mid-operation: reset overrides any write in the same cycle; all state returns to reset values at that edge.

Decomposition:
- Package riscv_mmio_pkg:
  - GPIO_BASE_ADDR constant.
  - Register offset constants OFF_OUT, OFF_IN, OFF_EDGE, OFF_SET, OFF_CLR.
  - Enum/localparam for register select.
  - Shared with the top-level read mux and the memory's address-range exclusion.
- Sub-module gpio_sync: parameterised-width 2-flop synchronizer with synchronous reset, reused for any future asynchronous input.

Test Plan:
- Reset then idle: gpio_out_o=8'h00; reads at BASE+0x00/0x08 return 0; Sel_o=1 at BASE, 0 at BASE+0x14 and BASE+0x02.
- Store 32'hFFFF_FFA5 to BASE+0x00 -> gpio_out_o=8'hA5 after that edge; read returns 32'h0000_00A5. OUT_SET 8'h0A -> 8'hAF. OUT_CLR 8'h05 -> 8'hAA.
- gpio_in_i 8'h00->8'h3C just before edge N -> IN reads 8'h3C after edge N+1; EDGE reads 8'h3C after edge N+2. gpio_in_i back to 0 -> EDGE unchanged.
- W1C 8'h0C to BASE+0x08 -> EDGE=8'h30. Repeat with a new rising edge on bit 2 in the same cycle as W1C of bit 2 -> bit 2 stays set.
- Store to BASE+0x04 and to an address outside the window with MemWrite_i=1 -> no change in OUT/EDGE; memory-region reads show Sel_o=0.
- Assert reset in the same cycle as a store of 8'hFF to OUT -> gpio_out_o=0. Pin held high through reset -> EDGE bit set exactly 3 cycles after release.
